riscv_zero_decode_pipe: RTL and testbench

Parametrised successor to the riscv_zero decode stage: accepts fetched instructions over a valid/ready handshake, decodes RV32I/RV64I base opcodes, reads an internal 32-entry register file, and presents a registered decode bundle to execute. Beyond the first-generation stage it adds configurable XLEN, back-pressure, flush, load-use bubble insertion and an illegal-opcode flag. Sits between fetch and execute; the writeback port comes from the end of the pipeline.

---
 rtl/riscv_zero_pkg.sv | 91 +++++++++
 rtl/riscv_zero_regfile.sv | 40 ++++
 rtl/riscv_zero_decode_pipe.sv | 134 +++++++++++++
 tb/tb_riscv_zero_decode_pipe.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_zero_pkg.sv
// Shared decode definitions for the riscv_zero decode pipe: opcodes,
// writeback-source encoding, immediate formats and the decoded-control
// bundle, plus the pure decode and immediate helpers.
package riscv_zero_pkg;

  localparam logic [6:0] OPC_LUI       = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
  localparam logic [6:0] OPC_JAL       = 7'b1101111;
  localparam logic [6:0] OPC_JALR      = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
  localparam logic [6:0] OPC_LOAD      = 7'b0000011;
  localparam logic [6:0] OPC_STORE     = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
  localparam logic [6:0] OPC_OP        = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
  localparam logic [6:0] OPC_OP_32     = 7'b0111011;

  localparam logic [1:0] WB_ALU = 2'd0;
  localparam logic [1:0] WB_MEM = 2'd1;
  localparam logic [1:0] WB_PC4 = 2'd2;

  typedef enum logic [2:0] {
    IMM_NONE, IMM_I, IMM_S, IMM_B, IMM_U, IMM_J
  } imm_fmt_e;

  // alu_a: 1 selects PC, 0 selects rs1. alu_b: 1 selects immediate, 0 rs2.
  typedef struct packed {
    logic       wb_en;
    logic       mem_we;
    logic       jump;
    logic       branch;
    logic       alu_a;
    logic       alu_b;
    logic       illegal;
    logic [1:0] wb_src;
    imm_fmt_e   imm_fmt;
    logic       use_rs1;
    logic       use_rs2;
  } ctrl_t;

  function automatic ctrl_t decode_ctrl(input logic [6:0] opc, input logic rv64);
    ctrl_t c;
    c = '0;
    case (opc)
      OPC_LUI:    begin c.wb_en = 1'b1; c.alu_b = 1'b1; c.imm_fmt = IMM_U; end
      OPC_AUIPC:  begin c.wb_en = 1'b1; c.alu_a = 1'b1; c.alu_b = 1'b1; c.imm_fmt = IMM_U; end
      OPC_JAL:    begin
        c.wb_en = 1'b1; c.jump = 1'b1; c.alu_a = 1'b1; c.alu_b = 1'b1;
        c.wb_src = WB_PC4; c.imm_fmt = IMM_J;
      end
      OPC_JALR:   begin
        c.wb_en = 1'b1; c.jump = 1'b1; c.alu_b = 1'b1;
        c.wb_src = WB_PC4; c.imm_fmt = IMM_I; c.use_rs1 = 1'b1;
      end
      OPC_BRANCH: begin c.branch = 1'b1; c.imm_fmt = IMM_B; c.use_rs1 = 1'b1; c.use_rs2 = 1'b1; end
      OPC_LOAD:   begin
        c.wb_en = 1'b1; c.alu_b = 1'b1; c.wb_src = WB_MEM;
        c.imm_fmt = IMM_I; c.use_rs1 = 1'b1;
      end
      OPC_STORE:  begin
        c.mem_we = 1'b1; c.alu_b = 1'b1; c.imm_fmt = IMM_S;
        c.use_rs1 = 1'b1; c.use_rs2 = 1'b1;
      end
      OPC_OP_IMM: begin c.wb_en = 1'b1; c.alu_b = 1'b1; c.imm_fmt = IMM_I; c.use_rs1 = 1'b1; end
      OPC_OP:     begin c.wb_en = 1'b1; c.use_rs1 = 1'b1; c.use_rs2 = 1'b1; end
      OPC_OP_IMM_32: begin
        if (rv64) begin c.wb_en = 1'b1; c.alu_b = 1'b1; c.imm_fmt = IMM_I; c.use_rs1 = 1'b1; end
        else c.illegal = 1'b1;
      end
      OPC_OP_32:  begin
        if (rv64) begin c.wb_en = 1'b1; c.use_rs1 = 1'b1; c.use_rs2 = 1'b1; end
        else c.illegal = 1'b1;
      end
      default:    c.illegal = 1'b1;
    endcase
    return c;
  endfunction

  // 32-bit sign-extended immediate; the top widens it to XLEN.
  function automatic logic [31:0] imm32(input imm_fmt_e f, input logic [31:0] i);
    case (f)
      IMM_I:   return {{20{i[31]}}, i[31:20]};
      IMM_S:   return {{20{i[31]}}, i[31:25], i[11:7]};
      IMM_B:   return {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
      IMM_U:   return {i[31:12], 12'b0};
      IMM_J:   return {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
      default: return 32'd0;
    endcase
  endfunction

endpackage

// File: rtl/riscv_zero_regfile.sv
// 32 x XLEN register file: two asynchronous read ports, one write port.
// x0 reads as zero. With RISCV_ZERO_WB_BYPASS_EN defined, a read of the
// register being written this cycle returns the write data; otherwise it
// returns the stored (pre-write) value.
module riscv_zero_regfile #(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [4:0]      raddr1_i,
  input  logic [4:0]      raddr2_i,
  output logic [XLEN-1:0] rdata1_o,
  output logic [XLEN-1:0] rdata2_o,
  input  logic            we_i,
  input  logic [4:0]      waddr_i,
  input  logic [XLEN-1:0] wdata_i
);

  logic [XLEN-1:0] regs_q [32];

  // Storage: cleared on reset, writes to x0 dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < 32; k++) regs_q[k] <= '0;
    end else if (we_i && (waddr_i != 5'd0)) begin
      regs_q[waddr_i] <= wdata_i;
    end
  end

  // Read ports with x0 forced to zero and optional same-cycle bypass.
  always_comb begin
    rdata1_o = (raddr1_i == 5'd0) ? '0 : regs_q[raddr1_i];
    rdata2_o = (raddr2_i == 5'd0) ? '0 : regs_q[raddr2_i];
`ifdef RISCV_ZERO_WB_BYPASS_EN
    if (we_i && (waddr_i == raddr1_i) && (raddr1_i != 5'd0)) rdata1_o = wdata_i;
    if (we_i && (waddr_i == raddr2_i) && (raddr2_i != 5'd0)) rdata2_o = wdata_i;
`endif
  end

endmodule

// File: rtl/riscv_zero_decode_pipe.sv
// Decode stage: valid/ready from fetch, registered decode bundle to execute,
// load-use bubble, flush and illegal-opcode flag. Optional macro
// RISCV_ZERO_WB_BYPASS_EN forwards same-cycle writeback data into captures.
module riscv_zero_decode_pipe
  import riscv_zero_pkg::*;
#(
  parameter int XLEN = 64,
  parameter int PC_W = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     inst_data,
  input  logic [PC_W-1:0] pc_in,
  input  logic            flush,
  input  logic            reg_wenable,
  input  logic [4:0]      reg_waddr,
  input  logic [XLEN-1:0] reg_wdata,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [6:0]      opcode,
  output logic [XLEN-1:0] immediate,
  output logic [4:0]      reg_dest,
  output logic [XLEN-1:0] reg1_out,
  output logic [XLEN-1:0] reg2_out,
  output logic [PC_W-1:0] pc_out,
  output logic            writeback_enable,
  output logic            mem_wenable,
  output logic            jump,
  output logic            branch,
  output logic            ALU_A_mux,
  output logic            ALU_B_mux,
  output logic            illegal,
  output logic [1:0]      writeback_source
);

  ctrl_t           ctrl_w;
  logic [31:0]     imm32_w;
  logic [XLEN-1:0] imm_w, rs1v_w, rs2v_w;
  logic [4:0]      rs1_w, rs2_w;
  logic            hazard, take;

  logic            vld_q, vld_d;
  logic [6:0]      opc_q;
  logic [XLEN-1:0] imm_q, rs1v_q, rs2v_q;
  logic [4:0]      rd_q;
  logic [PC_W-1:0] pc_q;
  logic            wb_q, mw_q, jmp_q, br_q, alu_a_q, alu_b_q, ill_q;
  logic [1:0]      src_q;

  assign rs1_w   = inst_data[19:15];
  assign rs2_w   = inst_data[24:20];
  assign ctrl_w  = decode_ctrl(inst_data[6:0], XLEN == 64);
  assign imm32_w = imm32(ctrl_w.imm_fmt, inst_data);
  assign imm_w   = XLEN'($signed(imm32_w));

  riscv_zero_regfile #(.XLEN(XLEN)) u_rf (
    .clk      (clk),
    .rst      (reset),
    .raddr1_i (rs1_w),
    .raddr2_i (rs2_w),
    .rdata1_o (rs1v_w),
    .rdata2_o (rs2v_w),
    .we_i     (reg_wenable),
    .waddr_i  (reg_waddr),
    .wdata_i  (reg_wdata)
  );

  // A held load whose rd is a source of the incoming instruction stalls it.
  assign hazard = vld_q && (opc_q == OPC_LOAD) && (rd_q != 5'd0) &&
                  ((ctrl_w.use_rs1 && (rs1_w == rd_q)) ||
                   (ctrl_w.use_rs2 && (rs2_w == rd_q)));

  // Flush drains fetch unconditionally; the consumed word is dropped.
  assign in_ready = flush || ((!vld_q || out_ready) && !hazard);
  assign take     = in_valid && in_ready && !flush;

  // Output-valid next state: flush beats capture beats drain.
  always_comb begin
    vld_d = vld_q;
    if (flush)          vld_d = 1'b0;
    else if (take)      vld_d = 1'b1;
    else if (out_ready) vld_d = 1'b0;
  end

  // Valid register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) vld_q <= 1'b0;
    else       vld_q <= vld_d;
  end

  // Decode bundle: loads on capture, otherwise holds.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      opc_q   <= '0;  imm_q   <= '0;  rd_q    <= '0;
      rs1v_q  <= '0;  rs2v_q  <= '0;  pc_q    <= '0;
      wb_q    <= 1'b0; mw_q   <= 1'b0; jmp_q  <= 1'b0; br_q <= 1'b0;
      alu_a_q <= 1'b0; alu_b_q <= 1'b0; ill_q <= 1'b0; src_q <= WB_ALU;
    end else if (take) begin
      opc_q   <= inst_data[6:0];
      imm_q   <= imm_w;
      rd_q    <= ctrl_w.wb_en ? inst_data[11:7] : 5'd0;
      rs1v_q  <= rs1v_w;
      rs2v_q  <= rs2v_w;
      pc_q    <= pc_in;
      wb_q    <= ctrl_w.wb_en;
      mw_q    <= ctrl_w.mem_we;
      jmp_q   <= ctrl_w.jump;
      br_q    <= ctrl_w.branch;
      alu_a_q <= ctrl_w.alu_a;
      alu_b_q <= ctrl_w.alu_b;
      ill_q   <= ctrl_w.illegal;
      src_q   <= ctrl_w.wb_src;
    end
  end

  assign out_valid        = vld_q;
  assign opcode           = opc_q;
  assign immediate        = imm_q;
  assign reg_dest         = rd_q;
  assign reg1_out         = rs1v_q;
  assign reg2_out         = rs2v_q;
  assign pc_out           = pc_q;
  assign writeback_enable = wb_q;
  assign mem_wenable      = mw_q;
  assign jump             = jmp_q;
  assign branch           = br_q;
  assign ALU_A_mux        = alu_a_q;
  assign ALU_B_mux        = alu_b_q;
  assign illegal          = ill_q;
  assign writeback_source = src_q;

endmodule

// File: tb/tb_riscv_zero_decode_pipe.sv
// Bench for riscv_zero_decode_pipe: constant vector table, directed
// handshake/hazard/flush/writeback sequences, then randomized traffic
// against an opcode-level reference model.
module tb_riscv_zero_decode_pipe;
  localparam int XLEN = 64;
  localparam int PC_W = 32;

  logic clk = 1'b0;
  logic reset, in_valid, in_ready, flush, reg_wenable, out_valid, out_ready;
  logic [31:0] inst_data;
  logic [PC_W-1:0] pc_in, pc_out;
  logic [4:0] reg_waddr, reg_dest;
  logic [XLEN-1:0] reg_wdata, immediate, reg1_out, reg2_out;
  logic [6:0] opcode;
  logic writeback_enable, mem_wenable, jump, branch, ALU_A_mux, ALU_B_mux, illegal;
  logic [1:0] writeback_source;

  always #5 clk = ~clk;

  riscv_zero_decode_pipe #(.XLEN(XLEN), .PC_W(PC_W)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .inst_data(inst_data), .pc_in(pc_in), .flush(flush),
    .reg_wenable(reg_wenable), .reg_waddr(reg_waddr), .reg_wdata(reg_wdata),
    .out_valid(out_valid), .out_ready(out_ready), .opcode(opcode),
    .immediate(immediate), .reg_dest(reg_dest), .reg1_out(reg1_out),
    .reg2_out(reg2_out), .pc_out(pc_out), .writeback_enable(writeback_enable),
    .mem_wenable(mem_wenable), .jump(jump), .branch(branch),
    .ALU_A_mux(ALU_A_mux), .ALU_B_mux(ALU_B_mux), .illegal(illegal),
    .writeback_source(writeback_source)
  );

  // ctl = {wb, mw, j, br, a, b, ill}
  typedef struct packed {
    logic [6:0]  opc;
    logic [63:0] imm;
    logic [4:0]  rd;
    logic [63:0] r1;
    logic [63:0] r2;
    logic [31:0] pc;
    logic [6:0]  ctl;
    logic [1:0]  src;
  } out_t;

  typedef struct { logic [31:0] ins; out_t exp; } vec_t;

  out_t act;
  assign act = {opcode, immediate, reg_dest, reg1_out, reg2_out, pc_out,
                writeback_enable, mem_wenable, jump, branch, ALU_A_mux, ALU_B_mux,
                illegal, writeback_source};

  int n_pass = 0, n_tot = 0;
  logic [63:0] mregs [32];
  logic [6:0] legal_ops [11] = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03,
                                 7'h23, 7'h13, 7'h33, 7'h1B, 7'h3B};
  logic [6:0] bad_ops [6] = '{7'h7F, 7'h0B, 7'h2F, 7'h57, 7'h77, 7'h00};

  task automatic chk(input string nm, input logic [255:0] got, input logic [255:0] exp);
    n_tot++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h required %h", nm, got, exp);
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  function automatic out_t mk(input logic [6:0] opc, input logic [63:0] imm, input logic [4:0] rd,
                              input logic [63:0] r1, input logic [63:0] r2, input logic [31:0] pc,
                              input logic [6:0] ctl, input logic [1:0] src);
    return {opc, imm, rd, r1, r2, pc, ctl, src};
  endfunction

  task automatic wr(input logic [4:0] a, input logic [63:0] d);
    reg_wenable = 1'b1; reg_waddr = a; reg_wdata = d;
    tick();
    reg_wenable = 1'b0;
  endtask

  // Reference: architectural register read as seen by a capture this cycle.
  function automatic logic [63:0] rdreg(input int a);
    if (a == 0) return 64'd0;
`ifdef RISCV_ZERO_WB_BYPASS_EN
    if (reg_wenable && (int'(reg_waddr) == a)) return reg_wdata;
`endif
    return mregs[a];
  endfunction

  // Reference decode: immediates from their ISA bit weights, controls per opcode.
  function automatic out_t ref_dec(input logic [31:0] ins, input logic [31:0] pc);
    out_t o;
    longint imm;
    logic wb, mw, j, br, a, b, ill;
    logic [1:0] src;
    o = '0; imm = 0;
    {wb, mw, j, br, a, b, ill} = 7'd0; src = 2'd0;
    case (ins[6:0])
      7'h37: begin wb = 1; b = 1; imm = longint'($signed(ins[31:12])) * 4096; end
      7'h17: begin wb = 1; a = 1; b = 1; imm = longint'($signed(ins[31:12])) * 4096; end
      7'h6F: begin
        wb = 1; j = 1; a = 1; b = 1; src = 2;
        imm = (ins[31] ? -longint'(1048576) : longint'(0)) + longint'(ins[19:12]) * 4096
              + longint'(ins[20]) * 2048 + longint'(ins[30:21]) * 2;
      end
      7'h67: begin wb = 1; j = 1; b = 1; src = 2; imm = longint'($signed(ins[31:20])); end
      7'h63: begin
        br = 1;
        imm = (ins[31] ? -longint'(4096) : longint'(0)) + longint'(ins[7]) * 2048
              + longint'(ins[30:25]) * 32 + longint'(ins[11:8]) * 2;
      end
      7'h03: begin wb = 1; b = 1; src = 1; imm = longint'($signed(ins[31:20])); end
      7'h23: begin mw = 1; b = 1; imm = longint'($signed({ins[31:25], ins[11:7]})); end
      7'h13, 7'h1B: begin wb = 1; b = 1; imm = longint'($signed(ins[31:20])); end
      7'h33, 7'h3B: wb = 1;
      default: ill = 1;
    endcase
    o.opc = ins[6:0];
    o.imm = imm;
    o.rd  = wb ? ins[11:7] : 5'd0;
    o.r1  = rdreg(int'(ins[19:15]));
    o.r2  = rdreg(int'(ins[24:20]));
    o.pc  = pc;
    o.ctl = {wb, mw, j, br, a, b, ill};
    o.src = src;
    return o;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vec_t tbl[16];
    out_t mout, mnext;
    logic mvld, mrdy, mhaz;
    logic [31:0] ins;
    logic [63:0] exp_byp;
    logic [6:0] h_opc;
    logic [4:0] h_rd;

    reset = 1'b1; in_valid = 0; flush = 0; reg_wenable = 0; out_ready = 1;
    inst_data = 0; pc_in = 0; reg_waddr = 0; reg_wdata = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_out_valid", out_valid, 1'b0);
    chk("reset_bundle", act, '0);
    reset = 1'b0; #1;
    chk("reset_in_ready", in_ready, 1'b1);
    tick();
    chk("post_reset_bundle", act, '0);

    wr(5'd1, 64'h100); wr(5'd2, 64'h22); wr(5'd5, 64'h1234);

    tbl[0]  = '{32'hFFF28313, mk(7'h13, '1,          5'd6,  64'h1234, 0, 0, 7'b1000010, 2'd0)};
    tbl[1]  = '{32'h123451B7, mk(7'h37, 64'h12345000, 5'd3,  0, 0, 0, 7'b1000010, 2'd0)};
    tbl[2]  = '{32'h800000B7, mk(7'h37, 64'hFFFFFFFF80000000, 5'd1, 0, 0, 0, 7'b1000010, 2'd0)};
    tbl[3]  = '{32'h00001217, mk(7'h17, 64'h1000,     5'd4,  0, 0, 0, 7'b1000110, 2'd0)};
    tbl[4]  = '{32'hFFDFF0EF, mk(7'h6F, 64'hFFFFFFFFFFFFFFFC, 5'd1, 0, 0, 0, 7'b1010110, 2'd2)};
    tbl[5]  = '{32'h004102E7, mk(7'h67, 64'd4,        5'd5,  64'h22, 0, 0, 7'b1010010, 2'd2)};
    tbl[6]  = '{32'h00208463, mk(7'h63, 64'd8,        5'd0,  64'h100, 64'h22, 0, 7'b0001000, 2'd0)};
    tbl[7]  = '{32'hFE209FE3, mk(7'h63, 64'hFFFFFFFFFFFFFFFE, 5'd0, 64'h100, 64'h22, 0, 7'b0001000, 2'd0)};
    tbl[8]  = '{32'h0020A623, mk(7'h23, 64'd12,       5'd0,  64'h100, 64'h22, 0, 7'b0100010, 2'd0)};
    tbl[9]  = '{32'hFE20AFA3, mk(7'h23, '1,           5'd0,  64'h100, 64'h22, 0, 7'b0100010, 2'd0)};
    tbl[10] = '{32'h00208433, mk(7'h33, 64'd0,        5'd8,  64'h100, 64'h22, 0, 7'b1000000, 2'd0)};
    tbl[11] = '{32'h0000A383, mk(7'h03, 64'd0,        5'd7,  64'h100, 0, 0, 7'b1000010, 2'd1)};
    tbl[12] = '{32'h0050851B, mk(7'h1B, 64'd5,        5'd10, 64'h100, 64'h1234, 0, 7'b1000010, 2'd0)};
    tbl[13] = '{32'h0000007F, mk(7'h7F, 64'd0,        5'd0,  0, 0, 0, 7'b0000001, 2'd0)};
    tbl[14] = '{32'hFFFFFFFF, mk(7'h7F, 64'd0,        5'd0,  0, 0, 0, 7'b0000001, 2'd0)};
    tbl[15] = '{32'h0000000B, mk(7'h0B, 64'd0,        5'd0,  0, 0, 0, 7'b0000001, 2'd0)};

    for (int i = 0; i < 16; i++) begin
      tbl[i].exp.pc = 32'h1000 + 32'(i * 4);
      inst_data = tbl[i].ins; pc_in = tbl[i].exp.pc; in_valid = 1'b1;
      #1;
      chk($sformatf("vec%0d_pre_valid", i), out_valid, 1'b0);
      tick();
      chk($sformatf("vec%0d_valid", i), out_valid, 1'b1);
      chk($sformatf("vec%0d_bundle", i), act, tbl[i].exp);
      in_valid = 1'b0;
      tick();
    end

    // Load-use: LW x7 then ADD x8,x7,x2 -> one bubble.
    inst_data = 32'h0000A383; in_valid = 1; tick();
    chk("lu_lw_out", {out_valid, opcode}, {1'b1, 7'h03});
    inst_data = 32'h00238433; #1;
    chk("lu_hazard_ready", in_ready, 1'b0);
    tick();
    chk("lu_bubble", out_valid, 1'b0);
    chk("lu_ready_after_bubble", in_ready, 1'b1);
    tick();
    chk("lu_add_out", {out_valid, opcode, reg_dest, reg2_out}, {1'b1, 7'h33, 5'd8, 64'h22});
    // Independent instruction behind a load, and load to x0: no stall.
    inst_data = 32'h0000A383; tick();
    inst_data = 32'h00208433; #1;
    chk("lu_nodep_ready", in_ready, 1'b1);
    inst_data = 32'h0000A003; tick();
    inst_data = 32'h00000433; #1;
    chk("lu_x0_ready", in_ready, 1'b1);
    in_valid = 0; tick();

    // Back-pressure: outputs stable while out_ready is low.
    inst_data = 32'hFFF28313; in_valid = 1; tick();
    inst_data = 32'h00208433; out_ready = 0;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk($sformatf("bp%0d_in_ready", c), in_ready, 1'b0);
      tick();
      chk($sformatf("bp%0d_hold", c), {out_valid, opcode, reg_dest, reg1_out},
          {1'b1, 7'h13, 5'd6, 64'h1234});
    end
    out_ready = 1; #1;
    chk("bp_release_ready", in_ready, 1'b1);
    tick();
    chk("bp_next_out", {out_valid, opcode, reg_dest}, {1'b1, 7'h33, 5'd8});
    in_valid = 0; tick();
    chk("bp_drain", out_valid, 1'b0);

    // Illegal opcode then flush with back-pressure asserted.
    inst_data = 32'h0000007F; in_valid = 1; tick();
    chk("ill_flags", {out_valid, illegal, writeback_enable, mem_wenable, jump, branch},
        6'b110000);
    inst_data = 32'hFFF28313; flush = 1; out_ready = 0; #1;
    chk("flush_in_ready", in_ready, 1'b1);
    tick();
    flush = 0; in_valid = 0;
    chk("flush_valid", out_valid, 1'b0);
    out_ready = 1; tick();
    chk("flush_discard", out_valid, 1'b0);

    // Same-cycle writeback and capture of x9; then x0 write is ignored.
`ifdef RISCV_ZERO_WB_BYPASS_EN
    exp_byp = 64'hAB;
`else
    exp_byp = 64'h0;
`endif
    reg_wenable = 1; reg_waddr = 5'd9; reg_wdata = 64'hAB;
    inst_data = 32'h00048513; in_valid = 1; tick();
    reg_wenable = 0;
    chk("wb_same_cycle", reg1_out, exp_byp);
    tick();
    chk("wb_next_cycle", reg1_out, 64'hAB);
    in_valid = 0; tick();
    wr(5'd0, 64'hFF);
    inst_data = 32'h00000313; in_valid = 1; tick();
    chk("x0_reads_zero", reg1_out, 64'd0);

    // Asynchronous reset with a valid bundle held.
    chk("pre_reset_valid", out_valid, 1'b1);
    reset = 1; #1;
    chk("async_reset_valid", out_valid, 1'b0);
    chk("async_reset_bundle", act, '0);
    in_valid = 0; tick();
    reset = 0;

    // Randomized traffic against the reference model.
    mvld = 0; mout = '0;
    for (int k = 0; k < 32; k++) mregs[k] = 64'd0;
    for (int cyc = 0; cyc < 500; cyc++) begin
      in_valid    = ($urandom_range(0, 3) != 0);
      out_ready   = ($urandom_range(0, 3) != 0);
      flush       = ($urandom_range(0, 19) == 0);
      reg_wenable = ($urandom_range(0, 2) == 0);
      reg_waddr   = 5'($urandom_range(0, 7));
      reg_wdata   = {$urandom, $urandom};
      ins = $urandom;
      if ($urandom_range(0, 12) < 11) ins[6:0] = legal_ops[$urandom_range(0, 10)];
      else ins[6:0] = bad_ops[$urandom_range(0, 5)];
      ins[11:7]  = 5'($urandom_range(0, 7));
      ins[19:15] = 5'($urandom_range(0, 7));
      ins[24:20] = 5'($urandom_range(0, 7));
      inst_data = ins; pc_in = $urandom;
      #1;
      h_opc = mout.opc; h_rd = mout.rd;
      mhaz = mvld && (h_opc == 7'h03) && (h_rd != 0) &&
             (((ins[6:0] inside {7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33, 7'h1B, 7'h3B})
               && ins[19:15] == h_rd) ||
              ((ins[6:0] inside {7'h63, 7'h23, 7'h33, 7'h3B}) && ins[24:20] == h_rd));
      mrdy = flush || ((!mvld || out_ready) && !mhaz);
      chk($sformatf("rnd%0d_in_ready", cyc), in_ready, mrdy);
      mnext = ref_dec(ins, pc_in);
      if (flush) mvld = 0;
      else if (in_valid && mrdy) begin mvld = 1; mout = mnext; end
      else if (out_ready) mvld = 0;
      if (reg_wenable && reg_waddr != 0) mregs[reg_waddr] = reg_wdata;
      tick();
      chk($sformatf("rnd%0d_valid", cyc), out_valid, mvld);
      chk($sformatf("rnd%0d_bundle", cyc), act, mout);
    end

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
